// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and the busy-class helper also used by hazard/decode logic.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic is_md_busy_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit owning HI/LO. Results are computed at issue,
// parked in shadow registers and committed when the latency counter expires.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(max_int(MULT_LAT, DIV_LAT) + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      hi_n_q, hi_n_d, lo_n_q, lo_n_d;
  logic             commit_q, commit_d;

  logic             idle;
  logic             div_zero;
  logic             div_ovf;
  logic [31:0]      divisor;
  logic [63:0]      prod_s;
  logic [63:0]      prod_u;
  logic signed [31:0] dvd_s, dvs_s, q_s, r_s;
  logic [31:0]      q_u, r_u;

  assign idle = (cnt_q == '0);
  assign busy = (start & is_md_busy_op(md_op)) | ~idle;

  // Zero divisor is replaced by 1 so the dividers never see it; commit is
  // suppressed instead so HI/LO stay untouched.
  assign div_zero = (rt_data == 32'd0);
  assign divisor  = div_zero ? 32'd1 : rt_data;
  assign div_ovf  = (rs_data == 32'h8000_0000) && (rt_data == 32'hFFFF_FFFF);
  assign dvd_s    = $signed(rs_data);
  assign dvs_s    = $signed(divisor);

  assign prod_s = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
  assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};
  assign q_u    = rs_data / divisor;
  assign r_u    = rs_data % divisor;

  always_comb begin
    q_s = dvd_s;
    r_s = '0;
    if (!div_ovf) begin
      q_s = dvd_s / dvs_s;
      r_s = dvd_s % dvs_s;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_n_d   = hi_n_q;
    lo_n_d   = lo_n_q;
    commit_d = commit_q;
    if (!idle) begin
      // New issues are ignored while an op is in flight.
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1) && commit_q) begin
        hi_d = hi_n_q;
        lo_d = lo_n_q;
      end
    end else if (start) begin
      case (md_op_e'(md_op))
        MD_MULT: begin
          cnt_d    = CNT_W'(MULT_LAT);
          hi_n_d   = prod_s[63:32];
          lo_n_d   = prod_s[31:0];
          commit_d = 1'b1;
        end
        MD_MULTU: begin
          cnt_d    = CNT_W'(MULT_LAT);
          hi_n_d   = prod_u[63:32];
          lo_n_d   = prod_u[31:0];
          commit_d = 1'b1;
        end
        MD_DIV: begin
          cnt_d    = CNT_W'(DIV_LAT);
          hi_n_d   = r_s;
          lo_n_d   = q_s;
          commit_d = ~div_zero;
        end
        MD_DIVU: begin
          cnt_d    = CNT_W'(DIV_LAT);
          hi_n_d   = r_u;
          lo_n_d   = q_u;
          commit_d = ~div_zero;
        end
        MD_MTHI: hi_d = rs_data;
        MD_MTLO: lo_d = rs_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_n_q   <= '0;
      lo_n_q   <= '0;
      commit_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_n_q   <= hi_n_d;
      lo_n_q   <= lo_n_d;
      commit_q <= commit_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
